// File: rtl/random_counter_checker_if.sv
// Sample/result bundle between a counter link and its checker.
// The checker takes the slave side; the driver of samples takes master.
interface random_counter_checker_if #(
  parameter int ERR_W = 8
);
  logic [2:0]       din;
  logic             din_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [2:0]       phase;
  logic [ERR_W-1:0] err_count;

  modport master (
    output din, din_valid, clr_cnt,
    input  locked, err, wrap, phase, err_count
  );

  modport slave (
    input  din, din_valid, clr_cnt,
    output locked, err, wrap, phase, err_count
  );
endinterface

// File: rtl/random_counter_checker.sv
// Lock-and-flywheel checker for the 3-bit JK random counter sequence.
// Hunts, verifies a run of transitions, then flags and counts mismatches.
module random_counter_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input logic clk,
  input logic clear,
  random_counter_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t           r_state, w_state;
  logic [2:0]       r_exp, w_exp;
  logic [3:0]       r_match_cnt, w_match_cnt;
  logic [3:0]       r_miss_cnt, w_miss_cnt;
  logic             r_locked, w_locked;
  logic             r_err, w_err;
  logic             r_wrap, w_wrap;
  logic [2:0]       r_phase, w_phase;
  logic [ERR_W-1:0] r_err_count, w_err_count;
  logic             w_hit;

  function automatic logic [2:0] f_next(input logic [2:0] v);
    logic [2:0] n;
    unique case (v)
      3'b000: n = 3'b100;
      3'b100: n = 3'b101;
      3'b101: n = 3'b001;
      3'b001: n = 3'b111;
      3'b111: n = 3'b110;
      3'b110: n = 3'b011;
      3'b011: n = 3'b010;
      3'b010: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] f_phase(input logic [2:0] v);
    logic [2:0] p;
    unique case (v)
      3'b000: p = 3'd0;
      3'b100: p = 3'd1;
      3'b101: p = 3'd2;
      3'b001: p = 3'd3;
      3'b111: p = 3'd4;
      3'b110: p = 3'd5;
      3'b011: p = 3'd6;
      3'b010: p = 3'd7;
    endcase
    return p;
  endfunction

  assign w_hit = (bus.din == r_exp);

  always_comb begin
    w_state     = r_state;
    w_exp       = r_exp;
    w_match_cnt = r_match_cnt;
    w_miss_cnt  = r_miss_cnt;
    w_locked    = r_locked;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    w_phase     = r_phase;
    w_err_count = r_err_count;
    if (bus.din_valid) begin
      unique case (r_state)
        HUNT: begin
          w_exp       = f_next(bus.din);
          w_match_cnt = '0;
          w_state     = VERIFY;
        end
        VERIFY: begin
          w_exp = f_next(bus.din);
          if (w_hit) begin
            w_match_cnt = r_match_cnt + 4'd1;
            if (r_match_cnt + 4'd1 == 4'(LOCK_CNT)) begin
              w_state    = LOCKED;
              w_locked   = 1'b1;
              w_phase    = f_phase(bus.din);
              w_miss_cnt = '0;
            end
          end else begin
            w_match_cnt = '0;
          end
        end
        LOCKED: begin
          if (w_hit) begin
            w_phase    = f_phase(bus.din);
            w_miss_cnt = '0;
            w_exp      = f_next(bus.din);
            w_wrap     = (bus.din == 3'b000);
          end else begin
            // Flywheel: keep predicting from our own phase, not the bad sample
            w_err      = 1'b1;
            w_exp      = f_next(r_exp);
            w_phase    = f_phase(r_exp);
            w_miss_cnt = r_miss_cnt + 4'd1;
            if (r_miss_cnt + 4'd1 == 4'(LOSS_CNT)) begin
              w_state    = HUNT;
              w_locked   = 1'b0;
              w_miss_cnt = '0;
            end
          end
        end
        default: w_state = HUNT;
      endcase
    end
    if (bus.clr_cnt)
      w_err_count = '0;
    else if (w_err && !(&r_err_count))
      w_err_count = r_err_count + 1'b1;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state     <= HUNT;
      r_exp       <= 3'b000;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_wrap      <= 1'b0;
      r_phase     <= 3'd0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state;
      r_exp       <= w_exp;
      r_match_cnt <= w_match_cnt;
      r_miss_cnt  <= w_miss_cnt;
      r_locked    <= w_locked;
      r_err       <= w_err;
      r_wrap      <= w_wrap;
      r_phase     <= w_phase;
      r_err_count <= w_err_count;
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err       = r_err;
  assign bus.wrap      = r_wrap;
  assign bus.phase     = r_phase;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_random_counter_checker.sv
// Bench for random_counter_checker: directed steps then random samples,
// two instances (8-bit and 2-bit error counters) against one sequence model.
module tb_random_counter_checker;

  localparam int LOCK = 3;
  localparam int LOSS = 2;

  logic clk;
  logic clear;

  random_counter_checker_if #(.ERR_W(8)) ifa ();
  random_counter_checker_if #(.ERR_W(2)) ifb ();

  random_counter_checker #(
    .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(8)
  ) dut_a (
    .clk(clk), .clear(clear), .bus(ifa.slave)
  );

  random_counter_checker #(
    .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(2)
  ) dut_b (
    .clk(clk), .clear(clear), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] seq [8] = '{3'b000, 3'b100, 3'b101, 3'b001,
                          3'b111, 3'b110, 3'b011, 3'b010};

  int n_cmp = 0;
  int n_bad = 0;

  // sequence model: position-based, pred = -1 means no reference yet
  bit m_locked;
  int m_pred;
  int m_run;
  int m_miss;
  int m_phase;
  bit m_err;
  bit m_wrap;
  int m_cnt8;
  int m_cnt2;

  function automatic int idx_of(input logic [2:0] v);
    for (int i = 0; i < 8; i++)
      if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic m_reset();
    m_locked = 0; m_pred = -1; m_run = 0; m_miss = 0;
    m_phase = 0; m_err = 0; m_wrap = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic m_apply(input bit v, input logic [2:0] d, input bit c);
    int k;
    k = idx_of(d);
    m_err = 0;
    m_wrap = 0;
    if (v) begin
      if (!m_locked) begin
        if (m_pred >= 0 && k == m_pred) begin
          m_run++;
          if (m_run == LOCK) begin
            m_locked = 1;
            m_phase = k;
            m_miss = 0;
          end
        end else begin
          m_run = 0;
        end
        m_pred = (k + 1) % 8;
      end else if (k == m_pred) begin
        m_phase = k;
        m_wrap = (k == 0);
        m_miss = 0;
        m_pred = (k + 1) % 8;
      end else begin
        m_err = 1;
        m_phase = m_pred;
        m_pred = (m_pred + 1) % 8;
        m_miss++;
        if (m_miss == LOSS) begin
          m_locked = 0;
          m_pred = -1;
          m_miss = 0;
          m_run = 0;
        end
      end
    end
    if (c) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (m_err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".locked"}, int'(ifa.locked), int'(m_locked));
    chk({tag, ".err"}, int'(ifa.err), int'(m_err));
    chk({tag, ".wrap"}, int'(ifa.wrap), int'(m_wrap));
    chk({tag, ".phase"}, int'(ifa.phase), m_phase);
    chk({tag, ".cnt8"}, int'(ifa.err_count), m_cnt8);
    chk({tag, ".cnt2"}, int'(ifb.err_count), m_cnt2);
    chk({tag, ".lockb"}, int'(ifb.locked), int'(m_locked));
  endtask

  task automatic step(input string tag, input bit v,
                      input logic [2:0] d, input bit c);
    ifa.din = d; ifa.din_valid = v; ifa.clr_cnt = c;
    ifb.din = d; ifb.din_valid = v; ifb.clr_cnt = c;
    @(posedge clk);
    #1;
    m_apply(v, d, c);
    chk_all(tag);
  endtask

  function automatic logic [2:0] good();
    return (m_pred >= 0) ? seq[m_pred] : 3'($urandom);
  endfunction

  function automatic logic [2:0] bad();
    return seq[(m_pred + 3) % 8];
  endfunction

  initial begin
    bit v, c;
    logic [2:0] d;
    m_reset();
    clear = 1'b0;
    ifa.din = '0; ifa.din_valid = 0; ifa.clr_cnt = 0;
    ifb.din = '0; ifb.din_valid = 0; ifb.clr_cnt = 0;
    #12;
    chk_all("reset");
    clear = 1'b1;

    step("lk0", 1, 3'b100, 0);
    step("lk1", 1, 3'b101, 0);
    step("lk2", 1, 3'b001, 0);
    chk("lk2.notyet", int'(ifa.locked), 0);
    step("lk3", 1, 3'b111, 0);
    chk("lk3.locked", int'(ifa.locked), 1);
    chk("lk3.phase", int'(ifa.phase), 4);

    step("se0", 1, 3'b110, 0);
    step("se1", 1, 3'b011, 0);
    step("se2", 1, 3'b101, 0);
    chk("se2.err", int'(ifa.err), 1);
    chk("se2.phase", int'(ifa.phase), 7);
    chk("se2.cnt", int'(ifa.err_count), 1);
    step("se3", 1, 3'b000, 0);
    chk("se3.wrap", int'(ifa.wrap), 1);
    chk("se3.phase", int'(ifa.phase), 0);

    step("clr", 1, 3'b100, 1);
    step("ls0", 1, 3'b111, 0);
    chk("ls0.locked", int'(ifa.locked), 1);
    step("ls1", 1, 3'b111, 0);
    chk("ls1.locked", int'(ifa.locked), 0);
    chk("ls1.cnt", int'(ifa.err_count), 2);
    step("rl0", 1, 3'b000, 0);
    step("rl1", 1, 3'b100, 0);
    step("rl2", 1, 3'b101, 0);
    step("rl3", 1, 3'b001, 0);
    chk("rl3.locked", int'(ifa.locked), 1);

    step("vg0", 1, 3'b111, 0);
    step("vg1", 1, 3'b110, 0);
    step("vg2", 1, 3'b011, 0);
    step("vg3", 1, 3'b010, 0);
    for (int i = 0; i < 5; i++) step("gap", 0, 3'($urandom), 0);
    step("vg4", 1, 3'b000, 0);
    chk("vg4.wrap", int'(ifa.wrap), 1);
    step("vg5", 1, 3'b100, 0);
    chk("vg5.wrap", int'(ifa.wrap), 0);

    for (int i = 0; i < 5; i++) begin
      step("satb", 1, bad(), 0);
      step("satg", 1, good(), 0);
    end
    chk("sat.cnt2", int'(ifb.err_count), 3);
    chk("sat.locked", int'(ifb.locked), 1);
    step("satclr", 1, good(), 1);
    chk("satclr.cnt2", int'(ifb.err_count), 0);

    #2 clear = 1'b0;
    #1;
    m_reset();
    chk_all("midrst");
    chk("midrst.locked", int'(ifa.locked), 0);
    #1 clear = 1'b1;
    step("hr0", 1, 3'b011, 0);
    step("hr1", 1, 3'b010, 0);
    step("hr2", 1, 3'b000, 0);
    step("hr3", 1, 3'b100, 0);
    chk("hr3.locked", int'(ifa.locked), 1);
    chk("hr3.phase", int'(ifa.phase), 1);

    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 9) < 8) ? good() : 3'($urandom);
      c = ($urandom_range(0, 24) == 0);
      step("rnd", v, d, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
